alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue/control unit that drives the combinational ALU and consumes its results. It accepts one 16-bit instruction at a time and decodes it into an 8-bit ALU op code and operands. It captures the ALU result and flags, maintains the 5-bit processor status register (PSR), and evaluates conditional branches against the PSR. It sits between instruction fetch and the register file on one side, and the ALU on the other.

## Interface

Parameters:
- `DATA_W`, 16, datapath width; only 16 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr`  in  16  instruction word.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  high only in IDLE.
- `rd_addr`, `rs_addr`  out  4  register-file read addresses (Rdest = instr[11:8], Rsrc = instr[3:0]).
- `rdest_data`, `rsrc_data`  in  16  register-file read data.
- `alu_a`, `alu_b`  out  16  ALU operands.
- `alu_op`  out  8  ALU op code.
- `alu_result`  in  16  ALU output.
- `alu_flags`  in  5  ALU flags.
- `wb_en`  out  1  one-cycle writeback strobe.
- `wb_addr`  out  4  writeback register.
- `wb_data`  out  16  writeback data.
- `psr`  out  5  status register: [0] C, [1] L, [2] F, [3] Z, [4] N.
- `branch_valid`  out  1  one-cycle pulse for a Bcond instruction.
- `branch_taken`  out  1  condition result; qualified by `branch_valid`.
- `branch_disp`  out  16  sign-extended instr[7:0].
- `illegal`  out  1  one-cycle pulse for an undecodable instruction.

## Operation

- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE to DECODE on `instr_valid && instr_ready`; the instruction is latched at that edge.
  - DECODE to EXEC unconditionally; `rd_addr` and `rs_addr` are driven here.
  - EXEC to WB unconditionally; `alu_result` and `alu_flags` are registered at the end of EXEC.
  - WB to IDLE unconditionally.
- Register form, instr[15:12] = 0000:
  - `alu_op` = {4'b0000, instr[7:4]} for ADD 05, SUB 09, OR 02, CMP 0B, AND 01, XOR 03, MOV 0D.
  - `alu_a` = Rsrc and `alu_b` = Rdest, so SUB yields Rdest−Rsrc.
- Immediate form: instr[15:12] ∈ {5,9,B,1,2,3,D}.
  - `alu_op` = {4'b0000, instr[15:12]}.
  - `alu_a` = imm8; `alu_b` = Rdest.
  - imm8 is sign-extended for ADD, SUB, CMP and MOV, and zero-extended for AND, OR and XOR.
- Shifts: instr[15:12] = 1000.
  - instr[7:4] = 0100 gives LSH (84); instr[7:4] = 0110 gives ASHU (86).
  - `alu_a` = Rdest; `alu_b` = Rsrc.
  - instr[7:4] = 000x gives LSHI, and 001x gives ASHUI.
  - For immediate shifts, `alu_b` = sign-extended instr[4:0].
- MOV: `alu_a` = source and `alu_b` = Rdest, but `wb_data` = the source operand itself, not `alu_result`.
- Writeback: `wb_en` fires for every ALU op except CMP/CMPI; `wb_addr` = Rdest.
- PSR update, at the EXEC→WB edge, on defined bits only:
  - ADD: C, Z, N.
  - SUB: Z, N.
  - AND, OR, XOR, LSH, ASHU: Z.
  - CMP: L, F, Z, N.
  - MOV: none.
  - Bits that are not updated hold their value. X values from the ALU are never loaded.
- Bcond: instr[15:12] = 1100, condition in instr[11:8]. Condition codes:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 HI: L. 5 LS: !L.
  - 6 GT: N. 7 LE: !N.
  - 8 FS: F. 9 FC: !F.
  - A LO: !L&!Z. B HS: L|Z.
  - C LT: !N&!Z. D GE: N|Z.
  - E UC: 1. F: 0.
- Illegal instructions: any other encoding.
  - `alu_op` = 00; no writeback, no PSR change.
  - `illegal` pulses in WB.

## Timing

- Latency: instruction accepted at edge 0.
  - DECODE in cycle 1; EXEC in cycle 2.
  - `wb_en`, `branch_valid` and `illegal` are high in cycle 3 only.
  - `instr_ready` is high again in cycle 4.
  - Throughput: one instruction per 4 cycles.
- `alu_a`, `alu_b` and `alu_op` are stable throughout EXEC. They are 0 in the other states.
- PSR reflects the new flags from cycle 3.
  - A Bcond accepted back-to-back evaluates against the updated PSR.
- `instr_valid` while not ready: the instruction is ignored; the source must hold it.
- Reset, at any time, asynchronously:
  - State goes to IDLE.
  - `psr`, `wb_en`, `wb_addr`, `wb_data`, `alu_a`, `alu_b`, `alu_op`, `branch_*`, `illegal`, `rd_addr` and `rs_addr` all go to 0.
  - `instr_ready` = 1 whenever state is IDLE, including during reset.
  - An in-flight instruction is discarded with no writeback.

## Configuration

- `ALU_ISSUE_BRANCH_EN` defined: Bcond is decoded and evaluated as above.
- Undefined:
  - Opcode 1100 is treated as illegal.
  - `branch_valid`, `branch_taken` and `branch_disp` are tied to 0.
  - The condition evaluator is not instantiated.

## Structure

- Shared package `alu_pkg` holds:
  - ALU op-code constants (ADD…ASHU).
  - PSR bit indices.
  - Condition-code constants.
  - The FSM state encoding.
- Sub-module `cond_eval`: combinational, takes psr[4:0] and cond[3:0] and returns taken. It is instantiated only under `ALU_ISSUE_BRANCH_EN`.

## Test plan

- Reset, then ADD R1,R2 with R1=0xFFFF and R2=0x0001 → `alu_op`=05 in EXEC; in cycle 3 `wb_en`=1, `wb_addr`=1, `wb_data`=0x0000; psr C=1, Z=1, N=0.
- CMPI R3,#-1 with R3=0x0005 → no `wb_en`; `alu_a`=0xFFFF; psr L=1, N=0, Z=0.
- CMP R4,R5 with both equal to 0x1234, then BEQ disp 0xF0 → `branch_valid` and `branch_taken`=1, `branch_disp`=0xFFF0. A following BNE → `branch_taken`=0.
- LSHI R6,#-2 with R6=0x0010 → `alu_op`=84, `alu_b`=0xFFFE, writeback 0x0004.
- Instruction 0x7000 → `illegal` pulse in cycle 3, `alu_op`=00, psr unchanged, `wb_en`=0.
- Assert `reset` during EXEC of ADD → no `wb_en`, psr=0, `instr_ready`=1; the next instruction completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/control slice: op codes, PSR bit
// positions, branch condition codes and the issue FSM state encoding.
package alu_pkg;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  // Which PSR bits each ALU op defines; every other bit keeps its old value.
  function automatic logic [4:0] psrMask(input logic [7:0] op);
    logic [4:0] m;
    m = 5'b00000;
    case (op)
      OP_ADD: begin
        m[PSR_C] = 1'b1;
        m[PSR_Z] = 1'b1;
        m[PSR_N] = 1'b1;
      end
      OP_SUB: begin
        m[PSR_Z] = 1'b1;
        m[PSR_N] = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ASHU: m[PSR_Z] = 1'b1;
      OP_CMP: begin
        m[PSR_L] = 1'b1;
        m[PSR_F] = 1'b1;
        m[PSR_Z] = 1'b1;
        m[PSR_N] = 1'b1;
      end
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// cond_eval: combinational branch condition evaluator, checks a 4-bit
// condition code against the current PSR.
module cond_eval
  import alu_pkg::*;
(
  input  logic [4:0] i_psr,
  input  logic [3:0] i_cond,
  output logic       o_taken
);

  logic w_c, w_l, w_f, w_z, w_n;

  assign w_c = i_psr[PSR_C];
  assign w_l = i_psr[PSR_L];
  assign w_f = i_psr[PSR_F];
  assign w_z = i_psr[PSR_Z];
  assign w_n = i_psr[PSR_N];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = !w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = !w_c;
      COND_HI: o_taken = w_l;
      COND_LS: o_taken = !w_l;
      COND_GT: o_taken = w_n;
      COND_LE: o_taken = !w_n;
      COND_FS: o_taken = w_f;
      COND_FC: o_taken = !w_f;
      COND_LO: o_taken = !w_l && !w_z;
      COND_HS: o_taken = w_l || w_z;
      COND_LT: o_taken = !w_n && !w_z;
      COND_GE: o_taken = w_n || w_z;
      COND_UC: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/DECODE/EXEC/WB issue FSM feeding the ALU and owning the PSR.
// Conditional branches are decoded only when ALU_ISSUE_BRANCH_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [3:0]        rd_addr,
  output logic [3:0]        rs_addr,
  input  logic [DATA_W-1:0] rdest_data,
  input  logic [DATA_W-1:0] rsrc_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [4:0]        alu_flags,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        psr,
  output logic              branch_valid,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_disp,
  output logic              illegal
);

  state_t            r_state;
  logic [15:0]       r_instr;
  logic [3:0]        r_rdAddr, r_rsAddr;
  logic [DATA_W-1:0] r_aluA, r_aluB;
  logic [7:0]        r_aluOp;
  logic              r_wbPend, r_isMov, r_illPend;
  logic [DATA_W-1:0] r_movData;
  logic [4:0]        r_psrMask;
  logic              r_wbEn;
  logic [3:0]        r_wbAddr;
  logic [DATA_W-1:0] r_wbData;
  logic [4:0]        r_psr;
  logic              r_illegal;

  logic [3:0]        w_opHi, w_ext;
  logic [DATA_W-1:0] w_immS, w_immZ, w_shImm;
  logic [7:0]        w_aluOp;
  logic [DATA_W-1:0] w_aluA, w_aluB, w_movData;
  logic              w_isAlu, w_isMov, w_isBranch, w_illegal;

  assign w_opHi = r_instr[15:12];
  assign w_ext  = r_instr[7:4];
  assign w_immS = {{(DATA_W-8){r_instr[7]}}, r_instr[7:0]};
  assign w_immZ = {{(DATA_W-8){1'b0}}, r_instr[7:0]};
  assign w_shImm = {{(DATA_W-5){r_instr[4]}}, r_instr[4:0]};

  // Decode runs during DECODE, when the register file returns data for rd_addr/rs_addr.
  always_comb begin
    w_aluOp    = OP_NONE;
    w_aluA     = '0;
    w_aluB     = '0;
    w_movData  = '0;
    w_isAlu    = 1'b0;
    w_isBranch = 1'b0;
    case (w_opHi)
      4'h0: begin
        case (w_ext)
          4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: begin
            w_aluOp   = {4'h0, w_ext};
            w_aluA    = rsrc_data;
            w_aluB    = rdest_data;
            w_movData = rsrc_data;
            w_isAlu   = 1'b1;
          end
          default: w_isAlu = 1'b0;
        endcase
      end
      4'h5, 4'h9, 4'hB, 4'hD: begin
        w_aluOp   = {4'h0, w_opHi};
        w_aluA    = w_immS;
        w_aluB    = rdest_data;
        w_movData = w_immS;
        w_isAlu   = 1'b1;
      end
      4'h1, 4'h2, 4'h3: begin
        w_aluOp = {4'h0, w_opHi};
        w_aluA  = w_immZ;
        w_aluB  = rdest_data;
        w_isAlu = 1'b1;
      end
      4'h8: begin
        case (w_ext)
          4'h4, 4'h6: begin
            w_aluOp = (w_ext == 4'h4) ? OP_LSH : OP_ASHU;
            w_aluA  = rdest_data;
            w_aluB  = rsrc_data;
            w_isAlu = 1'b1;
          end
          4'h0, 4'h1, 4'h2, 4'h3: begin
            w_aluOp = w_ext[1] ? OP_ASHU : OP_LSH;
            w_aluA  = rdest_data;
            w_aluB  = w_shImm;
            w_isAlu = 1'b1;
          end
          default: w_isAlu = 1'b0;
        endcase
      end
`ifdef ALU_ISSUE_BRANCH_EN
      4'hC: w_isBranch = 1'b1;
`endif
      default: w_isAlu = 1'b0;
    endcase
  end

  assign w_isMov   = (w_aluOp == OP_MOV);
  assign w_illegal = !w_isAlu && !w_isBranch;

`ifdef ALU_ISSUE_BRANCH_EN
  logic              r_brPend, r_brValid, r_brTaken;
  logic [DATA_W-1:0] r_brDisp;
  logic              w_taken;

  cond_eval u_condEval (
    .i_psr   (r_psr),
    .i_cond  (r_instr[11:8]),
    .o_taken (w_taken)
  );

  assign branch_valid = r_brValid;
  assign branch_taken = r_brTaken;
  assign branch_disp  = r_brDisp;
`else
  assign branch_valid = 1'b0;
  assign branch_taken = 1'b0;
  assign branch_disp  = '0;
`endif

  // Issue FSM; a reset in any state drops the in-flight instruction before writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_rdAddr  <= '0;
      r_rsAddr  <= '0;
      r_aluA    <= '0;
      r_aluB    <= '0;
      r_aluOp   <= OP_NONE;
      r_wbPend  <= 1'b0;
      r_isMov   <= 1'b0;
      r_illPend <= 1'b0;
      r_movData <= '0;
      r_psrMask <= '0;
      r_wbEn    <= 1'b0;
      r_wbAddr  <= '0;
      r_wbData  <= '0;
      r_psr     <= '0;
      r_illegal <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
      r_brPend  <= 1'b0;
      r_brValid <= 1'b0;
      r_brTaken <= 1'b0;
      r_brDisp  <= '0;
`endif
    end else begin
      r_wbEn    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
      r_brValid <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_instr  <= instr;
            r_rdAddr <= instr[11:8];
            r_rsAddr <= instr[3:0];
            r_state  <= DECODE;
          end
        end
        DECODE: begin
          r_aluOp   <= w_aluOp;
          r_aluA    <= w_aluA;
          r_aluB    <= w_aluB;
          r_wbPend  <= w_isAlu && (w_aluOp != OP_CMP);
          r_psrMask <= psrMask(w_aluOp);
          r_isMov   <= w_isMov;
          r_movData <= w_movData;
          r_illPend <= w_illegal;
          r_rdAddr  <= '0;
          r_rsAddr  <= '0;
`ifdef ALU_ISSUE_BRANCH_EN
          r_brPend  <= w_isBranch;
`endif
          r_state   <= EXEC;
        end
        EXEC: begin
          r_aluOp   <= OP_NONE;
          r_aluA    <= '0;
          r_aluB    <= '0;
          r_wbEn    <= r_wbPend;
          if (r_wbPend) begin
            r_wbAddr <= r_instr[11:8];
            r_wbData <= r_isMov ? r_movData : alu_result;
          end
          r_psr     <= (r_psr & ~r_psrMask) | (alu_flags & r_psrMask);
          r_illegal <= r_illPend;
`ifdef ALU_ISSUE_BRANCH_EN
          if (r_brPend) begin
            r_brValid <= 1'b1;
            r_brTaken <= w_taken;
            r_brDisp  <= w_immS;
          end
`endif
          r_state   <= WB;
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign rd_addr     = r_rdAddr;
  assign rs_addr     = r_rsAddr;
  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign alu_op      = r_aluOp;
  assign wb_en       = r_wbEn;
  assign wb_addr     = r_wbAddr;
  assign wb_data     = r_wbData;
  assign psr         = r_psr;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl with a behavioural register file and ALU.
// Branch expectations follow ALU_ISSUE_BRANCH_EN the same way as the design.
module tb_alu_issue_ctrl;

  typedef struct {
    string       tag;
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        wbEn;
    logic [3:0]  wbAddr;
    logic [15:0] wbData;
    logic        ill;
    logic        brValid;
    logic        brTaken;
    logic [15:0] brDisp;
    logic [4:0]  psr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic [3:0]  rdAddr, rsAddr;
  logic [15:0] rdestData, rsrcData;
  logic [15:0] aluA, aluB;
  logic [7:0]  aluOp;
  logic [15:0] aluResult;
  logic [4:0]  aluFlags;
  logic        wbEn;
  logic [3:0]  wbAddr;
  logic [15:0] wbData;
  logic [4:0]  psr;
  logic        branchValid, branchTaken;
  logic [15:0] branchDisp;
  logic        illegal;
  logic        regInit;
  logic [15:0] regs [16];

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instrValid),
    .instr_ready  (instrReady),
    .rd_addr      (rdAddr),
    .rs_addr      (rsAddr),
    .rdest_data   (rdestData),
    .rsrc_data    (rsrcData),
    .alu_a        (aluA),
    .alu_b        (aluB),
    .alu_op       (aluOp),
    .alu_result   (aluResult),
    .alu_flags    (aluFlags),
    .wb_en        (wbEn),
    .wb_addr      (wbAddr),
    .wb_data      (wbData),
    .psr          (psr),
    .branch_valid (branchValid),
    .branch_taken (branchTaken),
    .branch_disp  (branchDisp),
    .illegal      (illegal)
  );

  // Register file: combinational read, write on the writeback strobe.
  assign rdestData = regs[rdAddr];
  assign rsrcData  = regs[rsAddr];

  always @(posedge clk) begin
    if (regInit) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      regs[1] <= 16'hFFFF;
      regs[2] <= 16'h0001;
      regs[3] <= 16'h0005;
      regs[4] <= 16'h1234;
      regs[5] <= 16'h1234;
      regs[6] <= 16'h0010;
      regs[7] <= 16'h0100;
    end else if (wbEn) begin
      regs[wbAddr] <= wbData;
    end
  end

  // ALU model; flag bits an op leaves undefined are driven to 1 so masking is visible.
  always_comb begin
    logic [16:0] sum;
    logic [15:0] diff;
    logic [4:0]  mag;
    sum       = {1'b0, aluA} + {1'b0, aluB};
    diff      = aluB - aluA;
    mag       = aluB[4] ? (~aluB[4:0] + 5'd1) : aluB[4:0];
    aluResult = 16'h0000;
    aluFlags  = 5'b11111;
    case (aluOp)
      8'h05: begin
        aluResult = sum[15:0];
        aluFlags  = {sum[15], sum[15:0] == 16'h0000, 2'b11, sum[16]};
      end
      8'h09: begin
        aluResult = diff;
        aluFlags  = {diff[15], diff == 16'h0000, 3'b111};
      end
      8'h0B: aluFlags = {$signed(aluA) > $signed(aluB), aluA == aluB,
                         (aluB[15] != aluA[15]) && (diff[15] != aluB[15]),
                         aluA > aluB, 1'b1};
      8'h01: aluResult = aluA & aluB;
      8'h02: aluResult = aluA | aluB;
      8'h03: aluResult = aluA ^ aluB;
      8'h84: aluResult = aluB[4] ? (aluA >> mag) : (aluA << mag);
      8'h86: aluResult = aluB[4] ? 16'($signed(aluA) >>> mag) : (aluA << mag);
      8'h0D: aluResult = 16'hDEAD;
      default: aluResult = 16'h0000;
    endcase
    if (aluOp inside {8'h01, 8'h02, 8'h03, 8'h84, 8'h86})
      aluFlags = {1'b1, aluResult == 16'h0000, 3'b111};
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  function automatic exp_t mk(input string tag, input logic [7:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic ill, input logic bv,
                              input logic bt, input logic [15:0] bd, input logic [4:0] p);
    exp_t e;
    e.tag = tag; e.op = op; e.a = a; e.b = b;
    e.wbEn = we; e.wbAddr = wa; e.wbData = wd; e.ill = ill;
    e.brValid = bv; e.brTaken = bt; e.brDisp = bd; e.psr = p;
    return e;
  endfunction

  // Pops the oldest expectation while the DUT is in its WB cycle.
  task automatic checkOutput();
    exp_t e;
    check("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    check({e.tag, "_wb_en"}, 32'(wbEn), 32'(e.wbEn));
    if (e.wbEn) begin
      check({e.tag, "_wb_addr"}, 32'(wbAddr), 32'(e.wbAddr));
      check({e.tag, "_wb_data"}, 32'(wbData), 32'(e.wbData));
    end
    check({e.tag, "_illegal"}, 32'(illegal), 32'(e.ill));
    check({e.tag, "_br_valid"}, 32'(branchValid), 32'(e.brValid));
    if (e.brValid) begin
      check({e.tag, "_br_taken"}, 32'(branchTaken), 32'(e.brTaken));
      check({e.tag, "_br_disp"}, 32'(branchDisp), 32'(e.brDisp));
    end
    check({e.tag, "_psr"}, 32'(psr), 32'(e.psr));
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of cycle 4.
  task automatic applyStimulus(input logic [15:0] ins, input exp_t e);
    expQ.push_back(e);
    instr      = ins;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    instr      = 16'h0000;
    check({e.tag, "_rd_addr"}, 32'(rdAddr), 32'(ins[11:8]));
    @(negedge clk);
    @(negedge clk);
    check({e.tag, "_alu_op"}, 32'(aluOp), 32'(e.op));
    check({e.tag, "_alu_a"}, 32'(aluA), 32'(e.a));
    check({e.tag, "_alu_b"}, 32'(aluB), 32'(e.b));
    check({e.tag, "_busy"}, 32'(instrReady), 32'd0);
    @(negedge clk);
    checkOutput();
    @(negedge clk);
    check({e.tag, "_ready_again"}, 32'(instrReady), 32'd1);
    check({e.tag, "_wb_en_pulse"}, 32'(wbEn), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    regInit    = 1'b1;
    instr      = 16'h0000;
    instrValid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instrReady), 32'd1);
    check("rst_psr", 32'(psr), 32'd0);
    check("rst_wb_en", 32'(wbEn), 32'd0);
    check("rst_alu_op", 32'(aluOp), 32'd0);
    check("rst_br_valid", 32'(branchValid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset   = 1'b0;
    regInit = 1'b0;
    @(negedge clk);

    applyStimulus(16'h0152, mk("add", 8'h05, 16'h0001, 16'hFFFF, 1, 4'd1, 16'h0000, 0, 0, 0, 16'h0, 5'h09));
    applyStimulus(16'hB3FF, mk("cmpi", 8'h0B, 16'hFFFF, 16'h0005, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0, 5'h03));
    applyStimulus(16'h04B5, mk("cmp", 8'h0B, 16'h1234, 16'h1234, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0, 5'h09));
`ifdef ALU_ISSUE_BRANCH_EN
    applyStimulus(16'hC0F0, mk("beq", 8'h00, 16'h0, 16'h0, 0, 4'd0, 16'h0, 0, 1, 1, 16'hFFF0, 5'h09));
    applyStimulus(16'hC1F0, mk("bne", 8'h00, 16'h0, 16'h0, 0, 4'd0, 16'h0, 0, 1, 0, 16'hFFF0, 5'h09));
    applyStimulus(16'hCE05, mk("buc", 8'h00, 16'h0, 16'h0, 0, 4'd0, 16'h0, 0, 1, 1, 16'h0005, 5'h09));
`else
    applyStimulus(16'hC0F0, mk("beq", 8'h00, 16'h0, 16'h0, 0, 4'd0, 16'h0, 1, 0, 0, 16'h0, 5'h09));
    applyStimulus(16'hC1F0, mk("bne", 8'h00, 16'h0, 16'h0, 0, 4'd0, 16'h0, 1, 0, 0, 16'h0, 5'h09));
    applyStimulus(16'hCE05, mk("buc", 8'h00, 16'h0, 16'h0, 0, 4'd0, 16'h0, 1, 0, 0, 16'h0, 5'h09));
`endif
    applyStimulus(16'h861E, mk("lshi", 8'h84, 16'h0010, 16'hFFFE, 1, 4'd6, 16'h0004, 0, 0, 0, 16'h0, 5'h01));
    applyStimulus(16'h2780, mk("ori", 8'h02, 16'h0080, 16'h0100, 1, 4'd7, 16'h0180, 0, 0, 0, 16'h0, 5'h01));
    applyStimulus(16'h0394, mk("sub", 8'h09, 16'h1234, 16'h0005, 1, 4'd3, 16'hEDD1, 0, 0, 0, 16'h0, 5'h11));
    applyStimulus(16'hD8FD, mk("movi", 8'h0D, 16'hFFFD, 16'h0000, 1, 4'd8, 16'hFFFD, 0, 0, 0, 16'h0, 5'h11));
    applyStimulus(16'h7000, mk("ill", 8'h00, 16'h0000, 16'h0000, 0, 4'd0, 16'h0, 1, 0, 0, 16'h0, 5'h11));

    // Reset asserted while an ADD sits in EXEC.
    instr      = 16'h0757;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    instr      = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_exec_alu_op", 32'(aluOp), 32'h05);
    reset = 1'b1;
    #1;
    check("rst_mid_ready", 32'(instrReady), 32'd1);
    check("rst_mid_psr", 32'(psr), 32'd0);
    check("rst_mid_alu_op", 32'(aluOp), 32'd0);
    check("rst_mid_wb_en", 32'(wbEn), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_after_wb_en", 32'(wbEn), 32'd0);
    @(negedge clk);
    check("rst_after_ready", 32'(instrReady), 32'd1);
    check("rst_after_wb_en2", 32'(wbEn), 32'd0);
    check("rst_after_psr", 32'(psr), 32'd0);

    applyStimulus(16'h0297, mk("sub_post_rst", 8'h09, 16'h0180, 16'h0001, 1, 4'd2, 16'hFE81, 0, 0, 0, 16'h0, 5'h10));

    check("sb_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
